bootram_ctrl: RTL
=================

BOOTRAM_CTRL -- requirements
Module: bootram_ctrl

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000: byte base of the 8 KB boot RAM window; must be 8 KB aligned.
REQ-002 Parameter LANES, default 4: byte lanes (2Kx8 SP instances); fixed at 4.
REQ-003 The block SHALL use one clock, clk; reset is synchronous and active-high, named reset.
REQ-004 clk  in  1  system clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 mem_valid  in  1  CPU request (picorv32 native bus); held until mem_ready.
REQ-007 mem_addr  in  32  CPU byte address.
REQ-008 mem_wdata  in  32  CPU write data.
REQ-009 mem_wstrb  in  4  byte write strobes; 0 means read.
REQ-010 mem_ready  out  1  one-cycle completion pulse.
REQ-011 mem_rdata  out  32  read data, valid while mem_ready=1.
REQ-012 ld_valid  in  1  loader byte-write request; held until ld_ready.
REQ-013 ld_addr  in  13  loader byte offset within the window.
REQ-014 ld_data  in  8  loader byte.
REQ-015 ld_ready  out  1  one-cycle loader acknowledge.
REQ-016 wp  in  1  write-protect for CPU writes (loader unaffected).
REQ-017 wp_viol  out  1  sticky flag: a CPU write was dropped under wp.
REQ-018 ld_cnt  out  14  count of loader bytes written, saturating at 14'd8192.
REQ-019 ram_ce  out  4  per-lane CE.
REQ-020 ram_wre  out  4  per-lane WRE.
REQ-021 ram_oce  out  1  constant 1 (bypass read mode).
REQ-022 ram_reset  out  1  equals reset.
REQ-023 ram_ad  out  11  shared word address.
REQ-024 ram_din  out  32  lane i data = bits [8i+7:8i].
REQ-025 ram_dout  in  32  lane i read data in bits [8i+7:8i].

Function
REQ-026 The block SHALL accept CPU requests only when mem_addr[31:13]==BASE_ADDR[31:13]; others are ignored (mem_ready stays 0).
REQ-027 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; all ram_* outputs and mem_ready/ld_ready SHALL be registered.
REQ-028 IDLE: on a granted request, load ram_* registers and go to ISSUE; otherwise ram_ce=0, ram_wre=0.
REQ-029 Arbitration in IDLE SHALL be round-robin on a last-grant bit: with both pending, grant the one not granted last; last-grant resets to CPU (loader wins first tie).
REQ-030 CPU read: ram_ce=4'hF, ram_wre=0, ram_ad=mem_addr[12:2]; ISSUE->WAIT->RESP; mem_rdata<=ram_dout in WAIT; mem_ready=1 in RESP, i.e. 3 cycles after the IDLE sample cycle.
REQ-031 CPU write with wp=0: ram_ce=ram_wre=mem_wstrb, ram_din=mem_wdata; ISSUE->RESP; mem_ready at +2 cycles.
REQ-032 CPU write with wp=1: ram_ce=ram_wre=0, wp_viol<=1, still acknowledged with mem_ready at +2 cycles.
REQ-033 Loader write: lane k=ld_addr[1:0], ram_ce=ram_wre=one-hot k, ram_ad=ld_addr[12:2], ram_din replicates ld_data on all lanes; ISSUE->RESP; ld_ready at +2 cycles; ld_cnt increments in RESP unless already 8192.
REQ-034 RESP SHALL always return to IDLE; a request still high in the RESP cycle is not re-sampled until IDLE.
REQ-035 ram_ce/ram_wre SHALL be high for exactly one cycle (ISSUE) per access; mem_ready and ld_ready never both 1.
REQ-036 mem_rdata SHALL hold its value until the next CPU read.

Reset
REQ-037 On reset: state=IDLE, mem_ready=0, ld_ready=0, mem_rdata=0, ram_ce=0, ram_wre=0, ram_ad=0, ram_din=0, wp_viol=0, ld_cnt=0, last-grant=CPU.
REQ-038 Reset mid-access SHALL abort without acknowledge; a held request SHALL be re-served from IDLE after reset deasserts.

Structure
REQ-039 Shared package bootram_pkg SHALL hold the state enum, window size constant (8192) and lane count.
REQ-040 One sub-module, bootram_arb (2-way round-robin with last-grant register), is natural; datapath stays in bootram_ctrl.

Verification
REQ-041 Loader writes 0xAA to ld_addr 13'h0007 -> ram_wre=4'b1000, ram_ad=1, ld_ready 2 cycles later, ld_cnt=1.
REQ-042 CPU read 0x0000_0004 with ram_dout model returning 0x1234_5678 -> mem_ready 3 cycles after sample, mem_rdata=0x1234_5678.
REQ-043 CPU write 0xDEAD_BEEF, wstrb=4'b0011, wp=1 -> no ram_wre, mem_ready at +2, wp_viol=1 until reset.
REQ-044 CPU and loader both valid continuously from reset -> grants alternate L,C,L,C; no double acknowledge.
REQ-045 CPU read to 0x0000_2000 (outside window, BASE=0) -> no ram_ce, mem_ready stays 0 for 20 cycles.
REQ-046 Reset asserted in WAIT of a read -> no mem_ready; after release with mem_valid held, read completes 3 cycles after IDLE sample.

Source files
------------

// File: rtl/bootram_pkg.sv
// Shared types and constants for the 8 KB boot RAM controller.
// The RAM is four 2Kx8 byte lanes addressed by a common word address.
package bootram_pkg;

  localparam int unsigned WIN_BYTES = 8192;
  localparam int unsigned NUM_LANES = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    OP_RD,
    OP_WR,
    OP_LD
  } op_e;

  typedef enum logic {
    SRC_CPU = 1'b0,
    SRC_LD  = 1'b1
  } src_e;

endpackage

// File: rtl/bootram_arb.sv
// Two-way round-robin arbiter between the CPU and the loader.
// Grants are combinational; the last-grant register only moves when en is high.
module bootram_arb
  import bootram_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic req_cpu,
  input  logic req_ld,
  output logic gnt_cpu,
  output logic gnt_ld
);

  src_e last_q, last_d;

  always_comb begin
    // On a tie the requester that did not win last time goes first.
    gnt_ld  = en && req_ld && (!req_cpu || (last_q == SRC_CPU));
    gnt_cpu = en && req_cpu && !gnt_ld;
    last_d  = last_q;
    if (gnt_ld) begin
      last_d = SRC_LD;
    end else if (gnt_cpu) begin
      last_d = SRC_CPU;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= SRC_CPU;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/bootram_ctrl.sv
// Boot RAM controller: shares four byte-lane SRAMs between a picorv32 native
// bus port and a byte-wide loader, with CPU write protect and a loader counter.
module bootram_ctrl
  import bootram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          LANES     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  input  logic        ld_valid,
  input  logic [12:0] ld_addr,
  input  logic [7:0]  ld_data,
  output logic        ld_ready,
  input  logic        wp,
  output logic        wp_viol,
  output logic [13:0] ld_cnt,
  output logic [3:0]  ram_ce,
  output logic [3:0]  ram_wre,
  output logic        ram_oce,
  output logic        ram_reset,
  output logic [10:0] ram_ad,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout
);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic        mem_ready_q, mem_ready_d;
  logic        ld_ready_q, ld_ready_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic [3:0]  ram_ce_q, ram_ce_d;
  logic [3:0]  ram_wre_q, ram_wre_d;
  logic [10:0] ram_ad_q, ram_ad_d;
  logic [31:0] ram_din_q, ram_din_d;
  logic        wp_viol_q, wp_viol_d;
  logic [13:0] ld_cnt_q, ld_cnt_d;

  logic             cpu_hit;
  logic             gnt_cpu, gnt_ld;
  logic [LANES-1:0] ld_lane;
  logic [8*LANES-1:0] ld_din_rep;
  logic             unused_addr_bits;

  // Word-aligned bus: the two low address bits never select anything.
  assign unused_addr_bits = ^mem_addr[1:0];

  assign cpu_hit = mem_valid && (mem_addr[31:13] == BASE_ADDR[31:13]);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign ld_lane[gi]             = (ld_addr[1:0] == 2'(gi));
      assign ld_din_rep[8*gi +: 8]   = ld_data;
    end
  endgenerate

  bootram_arb u_arb (
    .clk     (clk),
    .reset   (reset),
    .en      (state_q == ST_IDLE),
    .req_cpu (cpu_hit),
    .req_ld  (ld_valid),
    .gnt_cpu (gnt_cpu),
    .gnt_ld  (gnt_ld)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    mem_ready_d = 1'b0;
    ld_ready_d  = 1'b0;
    mem_rdata_d = mem_rdata_q;
    ram_ce_d    = 4'h0;
    ram_wre_d   = 4'h0;
    ram_ad_d    = ram_ad_q;
    ram_din_d   = ram_din_q;
    wp_viol_d   = wp_viol_q;
    ld_cnt_d    = ld_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (gnt_ld) begin
          op_d      = OP_LD;
          ram_ce_d  = ld_lane;
          ram_wre_d = ld_lane;
          ram_ad_d  = ld_addr[12:2];
          ram_din_d = ld_din_rep;
          state_d   = ST_ISSUE;
        end else if (gnt_cpu) begin
          ram_ad_d = mem_addr[12:2];
          state_d  = ST_ISSUE;
          if (mem_wstrb == 4'h0) begin
            op_d     = OP_RD;
            ram_ce_d = 4'hF;
          end else begin
            // A protected write is dropped at the RAM but still acknowledged.
            op_d      = OP_WR;
            ram_din_d = mem_wdata;
            if (wp) begin
              wp_viol_d = 1'b1;
            end else begin
              ram_ce_d  = mem_wstrb;
              ram_wre_d = mem_wstrb;
            end
          end
        end
      end
      ST_ISSUE: begin
        if (op_q == OP_RD) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_RESP;
          if (op_q == OP_LD) begin
            ld_ready_d = 1'b1;
            if (ld_cnt_q != 14'(WIN_BYTES)) begin
              ld_cnt_d = ld_cnt_q + 14'd1;
            end
          end else begin
            mem_ready_d = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        mem_rdata_d = ram_dout;
        mem_ready_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_RD;
      mem_ready_q <= 1'b0;
      ld_ready_q  <= 1'b0;
      mem_rdata_q <= 32'h0;
      ram_ce_q    <= 4'h0;
      ram_wre_q   <= 4'h0;
      ram_ad_q    <= 11'h0;
      ram_din_q   <= 32'h0;
      wp_viol_q   <= 1'b0;
      ld_cnt_q    <= 14'h0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      mem_ready_q <= mem_ready_d;
      ld_ready_q  <= ld_ready_d;
      mem_rdata_q <= mem_rdata_d;
      ram_ce_q    <= ram_ce_d;
      ram_wre_q   <= ram_wre_d;
      ram_ad_q    <= ram_ad_d;
      ram_din_q   <= ram_din_d;
      wp_viol_q   <= wp_viol_d;
      ld_cnt_q    <= ld_cnt_d;
    end
  end

  assign mem_ready = mem_ready_q;
  assign mem_rdata = mem_rdata_q;
  assign ld_ready  = ld_ready_q;
  assign wp_viol   = wp_viol_q;
  assign ld_cnt    = ld_cnt_q;
  assign ram_ce    = ram_ce_q;
  assign ram_wre   = ram_wre_q;
  assign ram_oce   = 1'b1;
  assign ram_reset = reset;
  assign ram_ad    = ram_ad_q;
  assign ram_din   = ram_din_q;

endmodule
